full_add_arbiter: RTL and testbench

//  Shares one pipelined float_24_8 adder (fixed latency ADD_LAT) among NUM_REQ requesters.

---
 rtl/full_add_arbiter.sv | 158 +++++++++++++++
 tb/tb_full_add_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/full_add_arbiter.sv
// Round-robin front end for one shared pipelined float adder: tags each issued operand
// pair with its requester id and returns sums in issue order through a credit-gated FIFO.
module full_add_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ADD_LAT    = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*32-1:0]      req_a,
   input  logic [NUM_REQ*32-1:0]      req_b,
   output logic                       add_valid,
   output logic [31:0]                add_a,
   output logic [31:0]                add_b,
   input  logic [31:0]                add_result,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [$clog2(NUM_REQ)-1:0] rsp_id,
   output logic [31:0]                rsp_data,
   output logic                       busy
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int OUT_W = $clog2(FIFO_DEPTH + ADD_LAT + 1);
   localparam logic [ID_W:0] NUM_REQ_C = (ID_W + 1)'(NUM_REQ);

   logic [ID_W-1:0]                 rr_ptr_r;
   logic [ADD_LAT-1:0]              tag_valid_r;
   logic [ADD_LAT-1:0][ID_W-1:0]    tag_id_r;
   logic [ID_W-1:0]                 fifo_id_r   [FIFO_DEPTH];
   logic [31:0]                     fifo_data_r [FIFO_DEPTH];
   logic [PTR_W-1:0]                wr_ptr_r;
   logic [PTR_W-1:0]                rd_ptr_r;
   logic [CNT_W-1:0]                count_r;

   logic [ID_W-1:0]                 cand_s;
   logic                            hit_s;
   logic                            grant_valid_s;
   logic [ID_W-1:0]                 grant_id_s;
   logic [OUT_W-1:0]                outstanding_s;
   logic                            pop_s;
   logic                            push_s;
   logic                            can_issue_s;
   logic                            issue_s;

   function automatic logic [ID_W-1:0] wrap_id(input logic [ID_W:0] v);
      return ID_W'((v >= NUM_REQ_C) ? v - NUM_REQ_C : v);
   endfunction

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign rsp_valid = (count_r != '0);
   assign rsp_id    = fifo_id_r[rd_ptr_r];
   assign rsp_data  = fifo_data_r[rd_ptr_r];
   assign pop_s     = rsp_valid & rsp_ready;
   assign push_s    = tag_valid_r[ADD_LAT-1];
   assign busy      = (outstanding_s != '0);

   // Credit: ops in the adder pipe plus queued responses, with this cycle's pop freeing one slot
   always_comb begin
      outstanding_s = OUT_W'(count_r);
      for (int i = 0; i < ADD_LAT; i++) begin
         outstanding_s = outstanding_s + OUT_W'(tag_valid_r[i]);
      end
      can_issue_s = ((outstanding_s - OUT_W'(pop_s)) < OUT_W'(FIFO_DEPTH));
   end

   // First valid requester at or after the round-robin pointer
   always_comb begin
      grant_valid_s = 1'b0;
      grant_id_s    = '0;
      cand_s        = '0;
      hit_s         = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand_s        = wrap_id({1'b0, rr_ptr_r} + (ID_W + 1)'(i));
         hit_s         = req_valid[cand_s] & ~grant_valid_s;
         grant_id_s    = hit_s ? cand_s : grant_id_s;
         grant_valid_s = grant_valid_s | hit_s;
      end
   end

   assign issue_s = grant_valid_s & can_issue_s & ~reset;

   // Grant and adder operand mux are same-cycle so a granted pair is captured this edge
   always_comb begin
      if (issue_s) begin
         req_ready = NUM_REQ'(1) << grant_id_s;
         add_valid = 1'b1;
         add_a     = req_a[grant_id_s*32 +: 32];
         add_b     = req_b[grant_id_s*32 +: 32];
      end else begin
         req_ready = '0;
         add_valid = 1'b0;
         add_a     = 32'd0;
         add_b     = 32'd0;
      end
   end

   // Round-robin pointer advances past the winner only when something issues
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_r <= '0;
      end else if (issue_s) begin
         rr_ptr_r <= wrap_id({1'b0, grant_id_s} + (ID_W + 1)'(1));
      end
   end

   // Tag pipe mirrors the adder latency so the id lines up with add_result
   always_ff @(posedge clk) begin
      if (reset) begin
         tag_valid_r <= '0;
         tag_id_r    <= '0;
      end else begin
         tag_valid_r[0] <= issue_s;
         tag_id_r[0]    <= grant_id_s;
         for (int i = 1; i < ADD_LAT; i++) begin
            tag_valid_r[i] <= tag_valid_r[i-1];
            tag_id_r[i]    <= tag_id_r[i-1];
         end
      end
   end

   // Response storage; credit guarantees a free slot whenever a tag matures
   always_ff @(posedge clk) begin
      if (push_s && !reset) begin
         fifo_id_r[wr_ptr_r]   <= tag_id_r[ADD_LAT-1];
         fifo_data_r[wr_ptr_r] <= add_result;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= ptr_inc(wr_ptr_r);
         end
         if (pop_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: tb/tb_full_add_arbiter.sv
// Bench for full_add_arbiter: directed tables and sequences plus random traffic, all checked
// against a queue-based model of the arbitration, credit and in-order response rules.
module tb_full_add_arbiter;

   localparam int NUM   = 4;
   localparam int LAT   = 3;
   localparam int DEPTH = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic [3:0]   req_valid;
   logic [3:0]   req_ready;
   logic [127:0] req_a;
   logic [127:0] req_b;
   logic         add_valid;
   logic [31:0]  add_a;
   logic [31:0]  add_b;
   logic [31:0]  add_result;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [1:0]   rsp_id;
   logic [31:0]  rsp_data;
   logic         busy;

   always #5 clk = ~clk;

   full_add_arbiter #(.NUM_REQ(NUM), .ADD_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .add_valid(add_valid), .add_a(add_a), .add_b(add_b),
      .add_result(add_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
   );

   // Stand-in for the shared adder: exact for 1.0+2.0, a distinct pattern otherwise
   function automatic logic [31:0] add_ref(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
      return a ^ {b[15:0], b[31:16]} ^ 32'h0000_0001;
   endfunction

   logic [31:0] add_pipe [LAT];
   always @(posedge clk) begin
      add_pipe[0] <= add_valid ? add_ref(add_a, add_b) : 32'hBAD0_0BAD;
      for (int i = 1; i < LAT; i++) add_pipe[i] <= add_pipe[i-1];
   end
   assign add_result = add_pipe[LAT-1];

   typedef struct { int id; logic [31:0] data; int rem; } op_t;
   typedef struct { int id; logic [31:0] data; } rsp_t;
   op_t  inflight[$];
   rsp_t fifo_q[$];
   op_t  mv;
   int   m_ptr = 0;
   logic exp_gv;
   int   exp_g;
   int   dut_out = 0, grants = 0, pops = 0;
   int   checks = 0, errors = 0;

   logic [3:0]  s_ready;
   logic        s_rsp_valid, s_busy;
   logic [1:0]  s_id;
   logic [31:0] s_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input logic [3:0] rv, input logic rr, input logic rst);
      int          outst;
      logic        popm;
      logic [3:0]  exp_rdy;
      logic [31:0] ea, eb;
      reset = rst; req_valid = rv; rsp_ready = rr;
      @(negedge clk);
      s_ready = req_ready; s_rsp_valid = rsp_valid; s_id = rsp_id; s_data = rsp_data; s_busy = busy;
      outst  = inflight.size() + fifo_q.size();
      popm   = (fifo_q.size() != 0) && rr;
      exp_gv = 1'b0;
      exp_g  = 0;
      if (!rst && rv != 4'd0 && (outst - int'(popm)) < DEPTH) begin
         for (int k = 0; k < NUM; k++) begin
            if (!exp_gv && rv[(m_ptr + k) % NUM]) begin
               exp_gv = 1'b1;
               exp_g  = (m_ptr + k) % NUM;
            end
         end
      end
      exp_rdy = exp_gv ? (4'b0001 << exp_g) : 4'd0;
      ea      = exp_gv ? req_a[exp_g*32 +: 32] : 32'd0;
      eb      = exp_gv ? req_b[exp_g*32 +: 32] : 32'd0;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("add_valid", 32'(add_valid), 32'(exp_gv));
      chk("add_a", add_a, ea);
      chk("add_b", add_b, eb);
      if (!rst) begin
         chk("rsp_valid", 32'(rsp_valid), 32'(fifo_q.size() != 0));
         if (fifo_q.size() != 0) begin
            chk("rsp_id", 32'(rsp_id), 32'(fifo_q[0].id));
            chk("rsp_data", rsp_data, fifo_q[0].data);
         end
         chk("busy", 32'(busy), 32'(outst != 0));
         if ((req_valid & req_ready) != 4'd0) begin dut_out++; grants++; end
         if (rsp_valid && rr) begin dut_out--; pops++; end
         chk("credit_bound", 32'(dut_out <= DEPTH), 32'd1);
      end
      @(posedge clk);
      if (rst) begin
         inflight.delete(); fifo_q.delete();
         m_ptr = 0; dut_out = 0; grants = 0; pops = 0;
      end else begin
         if (popm) void'(fifo_q.pop_front());
         for (int k = 0; k < inflight.size(); k++) inflight[k].rem = inflight[k].rem - 1;
         while (inflight.size() != 0 && inflight[0].rem == 0) begin
            mv = inflight.pop_front();
            fifo_q.push_back('{mv.id, mv.data});
         end
         if (exp_gv) begin
            inflight.push_back('{exp_g, add_ref(ea, eb), LAT});
            m_ptr = (exp_g + 1) % NUM;
         end
      end
      #1;
   endtask

   typedef struct {
      logic [3:0] rv; logic rr; logic [3:0] exp_ready; logic exp_rsp_valid; logic [1:0] exp_id;
   } vec_t;
   vec_t tbl[8];

   initial begin
      int cnt;
      // Only req0 and req2 valid: grants alternate, responses follow LAT+1 cycles later
      tbl[0] = '{4'b0101, 1'b1, 4'b0001, 1'b0, 2'd0};
      tbl[1] = '{4'b0101, 1'b1, 4'b0100, 1'b0, 2'd0};
      tbl[2] = '{4'b0101, 1'b1, 4'b0001, 1'b0, 2'd0};
      tbl[3] = '{4'b0101, 1'b1, 4'b0100, 1'b0, 2'd0};
      tbl[4] = '{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0};
      tbl[5] = '{4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2};
      tbl[6] = '{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0};
      tbl[7] = '{4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2};

      reset = 1'b1; req_valid = 4'd0; rsp_ready = 1'b0;
      req_a = {$urandom, $urandom, $urandom, $urandom};
      req_b = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      step(4'd0, 1'b0, 1'b1);
      step(4'd0, 1'b0, 1'b1);
      step(4'd0, 1'b1, 1'b0);
      chk("reset_rsp_valid", 32'(s_rsp_valid), 32'd0);
      chk("reset_busy", 32'(s_busy), 32'd0);

      // Single op from req1: 1.0 + 2.0
      req_a[63:32] = 32'h3F80_0000;
      req_b[63:32] = 32'h4000_0000;
      step(4'b0010, 1'b1, 1'b0);
      chk("t1_grant", 32'(s_ready), 32'h2);
      for (int i = 1; i <= LAT; i++) begin
         step(4'd0, 1'b1, 1'b0);
         chk("t1_early", 32'(s_rsp_valid), 32'd0);
      end
      step(4'd0, 1'b1, 1'b0);
      chk("t1_rsp_valid", 32'(s_rsp_valid), 32'd1);
      chk("t1_rsp_id", 32'(s_id), 32'd1);
      chk("t1_rsp_data", s_data, 32'h4040_0000);
      step(4'd0, 1'b1, 1'b0);
      chk("t1_busy_after", 32'(s_busy), 32'd0);

      // All requesters valid from reset: full-rate round robin
      step(4'd0, 1'b1, 1'b1);
      for (int i = 0; i < 12; i++) begin
         step(4'hF, 1'b1, 1'b0);
         chk("t2_grant", 32'(s_ready), 32'(4'b0001 << (i % 4)));
         if (i >= LAT + 1) chk("t2_rsp_id", 32'(s_id), 32'((i - LAT - 1) % 4));
      end

      // Table-driven alternating pair
      step(4'd0, 1'b1, 1'b1);
      for (int i = 0; i < 8; i++) begin
         step(tbl[i].rv, tbl[i].rr, 1'b0);
         chk("t4_ready", 32'(s_ready), 32'(tbl[i].exp_ready));
         chk("t4_rsp_valid", 32'(s_rsp_valid), 32'(tbl[i].exp_rsp_valid));
         if (tbl[i].exp_rsp_valid) chk("t4_rsp_id", 32'(s_id), 32'(tbl[i].exp_id));
      end

      // Credit exhaustion with a stalled consumer, then release
      step(4'd0, 1'b1, 1'b1);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         step(4'hF, 1'b0, 1'b0);
         if (s_ready != 4'd0) cnt++;
      end
      chk("t3_grants", 32'(cnt), 32'd4);
      chk("t3_stalled_ready", 32'(s_ready), 32'd0);
      chk("t3_busy", 32'(s_busy), 32'd1);
      step(4'hF, 1'b1, 1'b0);
      chk("t3_resume", 32'(s_ready), 32'h1);
      chk("t3_first_id", 32'(s_id), 32'd0);
      for (int i = 1; i < 4; i++) begin
         step(4'd0, 1'b1, 1'b0);
         chk("t3_order", 32'(s_id), 32'(i));
      end
      for (int i = 0; i < 8; i++) step(4'd0, 1'b1, 1'b0);

      // Reset with three ops in flight
      for (int i = 0; i < 3; i++) step(4'hF, 1'b0, 1'b0);
      step(4'hC, 1'b0, 1'b1);
      chk("t5_ready_in_reset", 32'(s_ready), 32'd0);
      step(4'd0, 1'b1, 1'b0);
      chk("t5_rsp_valid", 32'(s_rsp_valid), 32'd0);
      chk("t5_busy", 32'(s_busy), 32'd0);
      step(4'hC, 1'b1, 1'b0);
      chk("t5_first_grant", 32'(s_ready), 32'h4);
      for (int i = 0; i < 8; i++) step(4'd0, 1'b1, 1'b0);

      // Random traffic with toggling then random consumer stalls
      for (int i = 0; i < 1500; i++) begin
         req_a = {$urandom, $urandom, $urandom, $urandom};
         req_b = {$urandom, $urandom, $urandom, $urandom};
         step(4'($urandom), (i < 200) ? ((i % 2) == 0) : ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 299) == 0));
      end
      for (int i = 0; i < 16; i++) step(4'd0, 1'b1, 1'b0);
      chk("t6_balance", 32'(pops), 32'(grants));
      chk("t6_idle", 32'(s_busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
